// File: rtl/blackjack_pkg.sv
// -----------------------------------------------------------------------------
// blackjack_pkg
// Shared types and constants for the card dealer and the stages around it.
//   card_t          4-bit card code: 0 = empty slot, 1..13 = Ace..King
//   CARD_EMPTY      code stored in an unfilled slot
//   CARD_MAX        highest legal card code (King)
//   MAX_CARDS       card slots per hand
//   dealer_state_t  dealer sequencing states
//   card_valid()    true when a 4-bit candidate is a legal card
// -----------------------------------------------------------------------------
package blackjack_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_MAX   = 4'd13;
  localparam int    MAX_CARDS  = 9;

  typedef enum logic [2:0] {
    IDLE,
    INIT_P0,
    INIT_D0,
    INIT_P1,
    INIT_D1,
    HIT_P,
    HIT_D,
    DONE
  } dealer_state_t;

  // Raw LFSR nibbles 0, 14 and 15 are not cards and get redrawn.
  function automatic logic card_valid(input card_t c);
    return (c != CARD_EMPTY) && (c <= CARD_MAX);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// -----------------------------------------------------------------------------
// card_lfsr
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
// Shifts left every cycle with the feedback bit entering bit 0.
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset; loads SEED
//   lfsr  current register contents
// SEED must be nonzero, otherwise the register locks up at zero.
// -----------------------------------------------------------------------------
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic feedback;

  // Taps for x^16, x^14, x^13 and x^11 are bits 15, 13, 12 and 10.
  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, whatever order the blocks evaluate in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[14:0], feedback};
    end
  end

endmodule

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
// Deals random cards into a player hand and a dealer hand. A new round clears
// both hands and deals P, D, P, D. A hit adds one card to one hand. The
// candidate card is the low nibble of a free-running LFSR. Nibbles outside
// 1..13 are rejected, and the draw is retried on the next cycle.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-low reset
//   new_round           pulse: clear both hands and start the 4-card deal
//                       (also aborts any draw in progress)
//   hit_player          pulse: deal one card to the player (IDLE only)
//   hit_dealer          pulse: deal one card to the dealer (IDLE only)
//   player_card_values  player slots, slot i at [4*i+3:4*i]; 0 = empty
//   dealer_card_values  dealer slots, same packing
//   player_count        number of filled player slots
//   dealer_count        number of filled dealer slots
//   busy                high in every state except IDLE
//   deal_done           one-cycle pulse after the last card of a request lands
//   hit_err             one-cycle pulse after a hit to a full hand is refused
// The card value outputs feed the card-value arrays of the totals stage.
// -----------------------------------------------------------------------------
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_CARDS = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_round,
  input  logic                   hit_player,
  input  logic                   hit_dealer,
  output logic [4*MAX_CARDS-1:0] player_card_values,
  output logic [4*MAX_CARDS-1:0] dealer_card_values,
  output logic [3:0]             player_count,
  output logic [3:0]             dealer_count,
  output logic                   busy,
  output logic                   deal_done,
  output logic                   hit_err
);

  import blackjack_pkg::*;

  localparam logic [3:0] FULL_COUNT = 4'(MAX_CARDS);

  dealer_state_t state_q;
  dealer_state_t state_d;

  logic [15:0] lfsr;
  logic [11:0] lfsr_unused;
  card_t       candidate;
  logic        card_ok;

  // Control decoded from the state and the request pulses.
  logic clear_hands;
  logic write_player;
  logic write_dealer;
  logic refuse_hit;

  logic [MAX_CARDS-1:0][3:0] player_slots;
  logic [MAX_CARDS-1:0][3:0] dealer_slots;

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  card_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  // Only the low nibble picks the card. The upper bits matter only inside the
  // shift chain.
  assign lfsr_unused = lfsr[15:4];
  assign candidate   = lfsr[3:0];
  assign card_ok     = card_valid(candidate);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and write strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    clear_hands  = 1'b0;
    write_player = 1'b0;
    write_dealer = 1'b0;
    refuse_hit   = 1'b0;

    if (new_round) begin
      // A new round wins in every state. When a draw is in progress, this
      // aborts it, so the aborted draw never reaches DONE and never pulses
      // deal_done.
      clear_hands = 1'b1;
      state_d     = INIT_P0;
    end else begin
      case (state_q)
        IDLE: begin
          // hit_player outranks hit_dealer. The losing pulse is dropped.
          if (hit_player) begin
            if (player_count < FULL_COUNT) state_d = HIT_P;
            else                           refuse_hit = 1'b1;
          end else if (hit_dealer) begin
            if (dealer_count < FULL_COUNT) state_d = HIT_D;
            else                           refuse_hit = 1'b1;
          end
        end
        INIT_P0: if (card_ok) begin write_player = 1'b1; state_d = INIT_D0; end
        INIT_D0: if (card_ok) begin write_dealer = 1'b1; state_d = INIT_P1; end
        INIT_P1: if (card_ok) begin write_player = 1'b1; state_d = INIT_D1; end
        INIT_D1: if (card_ok) begin write_dealer = 1'b1; state_d = DONE;    end
        HIT_P:   if (card_ok) begin write_player = 1'b1; state_d = DONE;    end
        HIT_D:   if (card_ok) begin write_dealer = 1'b1; state_d = DONE;    end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hands, counts and the refused-hit flag
  // ---------------------------------------------------------------------------
  // NOTE: the slot arrays are reset along with the rest of the state, because
  // downstream logic reads empty slots as 0 right after reset. Do not drop the
  // reset to save flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player_slots <= {MAX_CARDS{CARD_EMPTY}};
      dealer_slots <= {MAX_CARDS{CARD_EMPTY}};
      player_count <= 4'd0;
      dealer_count <= 4'd0;
      hit_err      <= 1'b0;
    end else begin
      hit_err <= refuse_hit;

      if (clear_hands) begin
        player_slots <= {MAX_CARDS{CARD_EMPTY}};
        dealer_slots <= {MAX_CARDS{CARD_EMPTY}};
        player_count <= 4'd0;
        dealer_count <= 4'd0;
      end else begin
        // The count doubles as the index of the next free slot.
        if (write_player) begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            if (player_count == 4'(i)) player_slots[i] <= candidate;
          end
          player_count <= player_count + 4'd1;
        end
        if (write_dealer) begin
          for (int i = 0; i < MAX_CARDS; i++) begin
            if (dealer_count == 4'(i)) dealer_slots[i] <= candidate;
          end
          dealer_count <= dealer_count + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign player_card_values = player_slots;
  assign dealer_card_values = dealer_slots;
  assign busy               = (state_q != IDLE);
  assign deal_done          = (state_q == DONE);

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
// Self-checking bench for card_dealer. A reference model predicts each request
// from the LFSR sequence alone. It walks the sequence from the current value,
// takes each low nibble in 1..13 as the next card in P,D,P,D (or single-hit)
// order, and counts how many cycles that takes. Hands are kept as queues.
// -----------------------------------------------------------------------------
module tb_card_dealer;

  import blackjack_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        new_round;
  logic        hit_player;
  logic        hit_dealer;
  logic [35:0] player_card_values;
  logic [35:0] dealer_card_values;
  logic [3:0]  player_count;
  logic [3:0]  dealer_count;
  logic        busy;
  logic        deal_done;
  logic        hit_err;

  card_dealer #(
    .LFSR_SEED (SEED),
    .MAX_CARDS (MAX_CARDS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .new_round          (new_round),
    .hit_player         (hit_player),
    .hit_dealer         (hit_dealer),
    .player_card_values (player_card_values),
    .dealer_card_values (dealer_card_values),
    .player_count       (player_count),
    .dealer_count       (dealer_count),
    .busy               (busy),
    .deal_done          (deal_done),
    .hit_err            (hit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // The LFSR runs freely, so its value is a pure function of the clock
  // count since reset.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= SEED;
    else      lfsr_m <= lfsr_next(lfsr_m);
  end

  int p_hand[$];
  int d_hand[$];
  logic [15:0] seen;

  function automatic logic [35:0] pack_hand(input int h[$]);
    logic [35:0] v;
    v = '0;
    foreach (h[i]) v[i*4 +: 4] = 4'(h[i]);
    return v;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " player_slots"}, player_card_values, pack_hand(p_hand));
    check({tag, " dealer_slots"}, dealer_card_values, pack_hand(d_hand));
    check({tag, " player_count"}, player_count, p_hand.size());
    check({tag, " dealer_count"}, dealer_count, d_hand.size());
  endtask

  task automatic note_seen();
    for (int i = 0; i < int'(player_count) && i < MAX_CARDS; i++)
      seen[player_card_values[i*4 +: 4]] = 1'b1;
    for (int i = 0; i < int'(dealer_count) && i < MAX_CARDS; i++)
      seen[dealer_card_values[i*4 +: 4]] = 1'b1;
  endtask

  // Issues one accepted request at the current negedge and follows it to
  // completion. With inject_hd set, a hit_dealer pulse is driven while the
  // request is still busy, and the model expects it to be dropped.
  task automatic request(input bit nr, input bit hp, input bit hd,
                         input bit inject_hd, input string tag);
    int          n;
    int          target[4];
    int          cards[4];
    logic [15:0] v;
    int          k;
    int          cycles;
    if (nr) begin
      n = 4;
      target = '{0, 1, 0, 1};
    end else begin
      n = 1;
      target = '{0, 0, 0, 0};
      target[0] = hp ? 0 : 1;
    end
    v = lfsr_m;
    k = 0;
    for (int c = 0; c < n; c++) begin
      do begin
        v = lfsr_next(v);
        k++;
      end while (!(v[3:0] >= 4'd1 && v[3:0] <= 4'd13));
      cards[c] = int'(v[3:0]);
    end

    new_round = nr; hit_player = hp; hit_dealer = hd;
    @(negedge clk);
    new_round = 1'b0; hit_player = 1'b0; hit_dealer = 1'b0;
    cycles = 1;
    if (nr) begin
      check({tag, " cleared_p"}, player_count, 0);
      check({tag, " cleared_d"}, dealer_count, 0);
    end
    check({tag, " busy"}, busy, 1'b1);
    if (inject_hd) hit_dealer = 1'b1;
    while (!deal_done && cycles < 200) begin
      @(negedge clk);
      hit_dealer = 1'b0;
      cycles++;
    end
    hit_dealer = 1'b0;
    check({tag, " deal_done_seen"}, deal_done, 1'b1);
    check({tag, " latency"}, cycles, k + 1);
    check({tag, " within_budget"}, cycles <= 32 * n + 1, 1'b1);

    if (nr) begin
      p_hand.delete();
      d_hand.delete();
    end
    for (int c = 0; c < n; c++) begin
      if (target[c] == 0) p_hand.push_back(cards[c]);
      else                d_hand.push_back(cards[c]);
    end

    @(negedge clk);
    check({tag, " deal_done_once"}, deal_done, 1'b0);
    check({tag, " idle"}, busy, 1'b0);
    compare_model(tag);
  endtask

  // A hit to a full hand: hit_err pulses once and nothing else moves.
  task automatic refused(input bit hp, input bit hd, input string tag);
    hit_player = hp; hit_dealer = hd;
    @(negedge clk);
    hit_player = 1'b0; hit_dealer = 1'b0;
    check({tag, " hit_err"}, hit_err, 1'b1);
    check({tag, " not_busy"}, busy, 1'b0);
    @(negedge clk);
    check({tag, " hit_err_once"}, hit_err, 1'b0);
    check({tag, " no_done"}, deal_done, 1'b0);
    compare_model(tag);
  endtask

  task automatic check_reset_state(input string tag);
    compare_model(tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " deal_done"}, deal_done, 1'b0);
    check({tag, " hit_err"}, hit_err, 1'b0);
    check({tag, " lfsr"}, dut.u_lfsr.lfsr, SEED);
  endtask

  // Any hang ends the run with a report instead of stalling forever.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    int waited;
    rst = 1'b0; new_round = 1'b0; hit_player = 1'b0; hit_dealer = 1'b0;
    seen = '0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b1;
    @(negedge clk);

    // Initial deal, then the priority and busy-drop cases.
    request(1'b1, 1'b0, 1'b0, 1'b0, "deal1");
    request(1'b0, 1'b1, 1'b1, 1'b0, "both_hits");
    request(1'b0, 1'b1, 1'b0, 1'b1, "hd_while_busy");

    // Fill the player hand to 9, then one hit too many.
    request(1'b1, 1'b0, 1'b0, 1'b0, "deal2");
    for (int i = 0; i < 7; i++) request(1'b0, 1'b1, 1'b0, 1'b0, "fill_p");
    check("fill_p final_count", player_count, 4'd9);
    refused(1'b1, 1'b0, "full_p");

    // new_round while HIT_D is pending: abort, no deal_done for the hit.
    hit_dealer = 1'b1;
    @(negedge clk);
    hit_dealer = 1'b0;
    check("abort in_hit_d busy", busy, 1'b1);
    check("abort in_hit_d no_done", deal_done, 1'b0);
    request(1'b1, 1'b0, 1'b0, 1'b0, "abort_deal");

    // Reset during INIT_D0.
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    waited = 0;
    while (player_count != 4'd1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("mid_reset reach_init_d0 p", player_count, 4'd1);
    check("mid_reset reach_init_d0 d", dealer_count, 4'd0);
    #1 rst = 1'b0;
    p_hand.delete();
    d_hand.delete();
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        request(1'b1, 1'b0, 1'b0, 1'b0, "rand_deal");
      end else if (r <= 5) begin
        if (p_hand.size() >= MAX_CARDS) refused(1'b1, 1'b0, "rand_full_p");
        else                            request(1'b0, 1'b1, 1'b0, 1'b0, "rand_hit_p");
      end else begin
        if (d_hand.size() >= MAX_CARDS) refused(1'b0, 1'b1, "rand_full_d");
        else                            request(1'b0, 1'b0, 1'b1, 1'b0, "rand_hit_d");
      end
      note_seen();
    end
    check("value_coverage", seen, 16'h3FFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, nonzero initial LFSR state loaded at reset.
REQ-002 Parameter MAX_CARDS, default 9, card slots per hand.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 new_round  input  1  one-cycle pulse: clear both hands, start initial deal.
REQ-006 hit_player  input  1  one-cycle pulse: deal one card to the player.
REQ-007 hit_dealer  input  1  one-cycle pulse: deal one card to the dealer.
REQ-008 player_card_values  output  9x4  player slots; 0 = empty, 1..13 = Ace..King.
REQ-009 dealer_card_values  output  9x4  dealer slots; same encoding.
REQ-010 player_count, dealer_count  output  4 each  number of filled slots, 0..9.
REQ-011 busy  output  1  high while any draw is pending.
REQ-012 deal_done  output  1  one-cycle pulse after the last card of a request is written.
REQ-013 hit_err  output  1  one-cycle pulse when a hit is refused because the hand is full.
REQ-014 The card value outputs SHALL be the sources for the card-value arrays of the SM_if out modport used by the totals stage.

Function
REQ-015 The 16-bit Fibonacci LFSR SHALL implement x^16+x^14+x^13+x^11+1, shift left every clk cycle with feedback into bit 0, and run freely in all states.
REQ-016 Each cycle in a draw state, the dealer SHALL accept candidate c = lfsr[3:0] only if 1 <= c <= 13; otherwise it SHALL write nothing and retry on the next cycle.
REQ-017 An accepted card SHALL be written at that clock edge into slot [count] of the target hand, which increments count; the new value SHALL be visible on the outputs the following cycle.
REQ-018 FSM states SHALL be IDLE, INIT_P0, INIT_D0, INIT_P1, INIT_D1, HIT_P, HIT_D and DONE.
REQ-019 IDLE + new_round: clear all 18 slots and both counts to 0 in the same edge -> INIT_P0.
REQ-020 Each INIT_x state SHALL wait for one accepted card, then advance in the order P0->D0->P1->D1->DONE.
REQ-021 IDLE + hit_player with player_count<9 -> HIT_P; HIT_P on accept -> DONE.
REQ-022 IDLE + hit_dealer with dealer_count<9 -> HIT_D; HIT_D on accept -> DONE.
REQ-023 DONE SHALL assert deal_done for one cycle and return to IDLE.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 Priority in IDLE SHALL be new_round > hit_player > hit_dealer; lower-priority pulses in the same cycle are dropped.
REQ-026 A new_round in any non-IDLE state SHALL abort the current deal, clear both hands and enter INIT_P0; no deal_done SHALL be pulsed for the aborted deal.
REQ-027 Hits arriving while busy SHALL be ignored, with no queuing and no hit_err.
REQ-028 A hit in IDLE to a hand whose count is 9 SHALL pulse hit_err on the next cycle and leave all state unchanged.
REQ-029 Slot values SHALL never hold 14 or 15; counts SHALL never exceed 9.

Reset
REQ-030 On rst low, the block SHALL immediately reach: all slots 0, counts 0, busy 0, deal_done 0, hit_err 0, FSM IDLE, LFSR = LFSR_SEED.
REQ-031 Reset asserted during a draw SHALL discard the draw; normal operation SHALL resume on the first edge after rst is released.

Structure
REQ-032 Shared package blackjack_pkg SHALL hold: card_t (4-bit), CARD_EMPTY=0, CARD_MAX=13, MAX_CARDS=9, and the dealer_state_t enum.
REQ-033 The LFSR SHALL be a separate sub-module, card_lfsr (inputs clk, rst; output lfsr[15:0]; parameter SEED).

Verification
REQ-034 Reset mid-INIT_D0 -> on the next cycle all 18 slots are 0, counts are 0/0, busy is 0 and lfsr is 16'hACE1.
REQ-035 new_round from IDLE -> exactly 4 writes in P,D,P,D order; counts 2/2; slots 2..8 are 0; values match the LFSR reference model; deal_done pulses once; each draw completes in 32 cycles or fewer.
REQ-036 Seven hit_player pulses after a deal -> player_count 9, dealer untouched; an 8th hit -> hit_err pulses once with no state change.
REQ-037 hit_player and hit_dealer together in IDLE -> only player_count increments; a hit_dealer during busy -> dropped.
REQ-038 new_round pulsed during HIT_D -> hands clear, no deal_done for the hit, then a fresh 4-card deal to counts 2/2.
REQ-039 Random run of 10k requests -> no slot ever holds 0 within count, or 14/15; every value 1..13 is observed at least once.
